// File: rtl/ftdi_rx_mass_checker_if.sv
// Stream bundle between the mass-transfer checker and the ftdi_245fifo_top user side
// (8-bit RX towards the checker, 32-bit TX response back to the FIFO).
interface ftdi_rx_mass_checker_if;
  logic        rx_tready;
  logic        rx_tvalid;
  logic [7:0]  rx_tdata;
  logic        tx_tready;
  logic        tx_tvalid;
  logic [31:0] tx_tdata;
  logic [3:0]  tx_tkeep;
  logic        tx_tlast;

  modport master (
    output rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast,
    input  rx_tvalid, rx_tdata, tx_tready
  );

  modport slave (
    input  rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast,
    output rx_tvalid, rx_tdata, tx_tready
  );
endinterface

// File: rtl/ftdi_rx_mass_checker.sv
// Host->FPGA mass-transfer checker: 4-byte LE length header, incrementing-pattern payload check,
// status response on TX. Define RX_MASS_FIRSTERR_EN to append the first-mismatch index word.
module ftdi_rx_mass_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [7:0]  PAT_SEED       = 8'h00
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  ftdi_rx_mass_checker_if.master        io_ftdi,
  output logic                          o_busy,
  output logic                          o_err_seen
);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_RESP} state_t;

`ifdef RX_MASS_FIRSTERR_EN
  localparam logic [1:0] LAST_WORD = 2'd2;
`else
  localparam logic [1:0] LAST_WORD = 2'd1;
`endif

  state_t      r_state,     nxt_state;
  logic [31:0] r_len,       nxt_len;
  logic [1:0]  r_hdr_cnt,   nxt_hdr_cnt;
  logic [31:0] r_idx,       nxt_idx;
  logic [31:0] r_err_cnt,   nxt_err_cnt;
  logic [31:0] r_idle,      nxt_idle;
  logic        r_timeout,   nxt_timeout;
  logic [1:0]  r_word,      nxt_word;
  logic        r_rx_tready, nxt_rx_tready;
  logic        r_tx_tvalid, nxt_tx_tvalid;
  logic [31:0] r_tx_tdata,  nxt_tx_tdata;
  logic [3:0]  r_tx_tkeep,  nxt_tx_tkeep;
  logic        r_tx_tlast,  nxt_tx_tlast;
  logic        r_busy,      nxt_busy;
  logic        r_err_seen,  nxt_err_seen;
`ifdef RX_MASS_FIRSTERR_EN
  logic [31:0] r_first_err, nxt_first_err;
`endif

  logic       w_rx_beat;
  logic       w_tx_beat;
  logic [7:0] w_exp_byte;
  logic       w_mismatch;
  logic       w_idle_expired;

  assign w_rx_beat      = io_ftdi.rx_tvalid & r_rx_tready;
  assign w_tx_beat      = r_tx_tvalid & io_ftdi.tx_tready;
  assign w_exp_byte     = PAT_SEED + r_idx[7:0];
  assign w_mismatch     = (io_ftdi.rx_tdata != w_exp_byte);
  assign w_idle_expired = (r_idle == TIMEOUT_CYCLES - 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_HDR;
      r_len       <= '0;
      r_hdr_cnt   <= '0;
      r_idx       <= '0;
      r_err_cnt   <= '0;
      r_idle      <= '0;
      r_timeout   <= 1'b0;
      r_word      <= '0;
      r_rx_tready <= 1'b0;
      r_tx_tvalid <= 1'b0;
      r_tx_tdata  <= '0;
      r_tx_tkeep  <= '0;
      r_tx_tlast  <= 1'b0;
      r_busy      <= 1'b0;
      r_err_seen  <= 1'b0;
`ifdef RX_MASS_FIRSTERR_EN
      r_first_err <= '1;
`endif
    end else begin
      r_state     <= nxt_state;
      r_len       <= nxt_len;
      r_hdr_cnt   <= nxt_hdr_cnt;
      r_idx       <= nxt_idx;
      r_err_cnt   <= nxt_err_cnt;
      r_idle      <= nxt_idle;
      r_timeout   <= nxt_timeout;
      r_word      <= nxt_word;
      r_rx_tready <= nxt_rx_tready;
      r_tx_tvalid <= nxt_tx_tvalid;
      r_tx_tdata  <= nxt_tx_tdata;
      r_tx_tkeep  <= nxt_tx_tkeep;
      r_tx_tlast  <= nxt_tx_tlast;
      r_busy      <= nxt_busy;
      r_err_seen  <= nxt_err_seen;
`ifdef RX_MASS_FIRSTERR_EN
      r_first_err <= nxt_first_err;
`endif
    end
  end

  // Outputs are registered copies of next-state values, so word0 appears the cycle after
  // the final RX beat (or the timeout decision) without an extra pipeline stage.
  always_comb begin
    nxt_state     = r_state;
    nxt_len       = r_len;
    nxt_hdr_cnt   = r_hdr_cnt;
    nxt_idx       = r_idx;
    nxt_err_cnt   = r_err_cnt;
    nxt_idle      = r_idle;
    nxt_timeout   = r_timeout;
    nxt_word      = r_word;
    nxt_tx_tvalid = r_tx_tvalid;
    nxt_tx_tdata  = r_tx_tdata;
    nxt_tx_tlast  = r_tx_tlast;
    nxt_err_seen  = r_err_seen;
`ifdef RX_MASS_FIRSTERR_EN
    nxt_first_err = r_first_err;
`endif

    unique case (r_state)
      S_HDR: begin
        if (w_rx_beat) begin
          nxt_idle = '0;
          unique case (r_hdr_cnt)
            2'd0: nxt_len[7:0]   = io_ftdi.rx_tdata;
            2'd1: nxt_len[15:8]  = io_ftdi.rx_tdata;
            2'd2: nxt_len[23:16] = io_ftdi.rx_tdata;
            default: nxt_len[31:24] = io_ftdi.rx_tdata;
          endcase
          nxt_hdr_cnt = r_hdr_cnt + 2'd1;
          if (r_hdr_cnt == 2'd3) begin
            nxt_idx     = '0;
            nxt_err_cnt = '0;
            nxt_timeout = 1'b0;
`ifdef RX_MASS_FIRSTERR_EN
            nxt_first_err = '1;
`endif
            if (nxt_len == '0) begin
              nxt_state     = S_RESP;
              nxt_word      = '0;
              nxt_tx_tvalid = 1'b1;
              nxt_tx_tdata  = nxt_len;
              nxt_tx_tlast  = 1'b0;
            end else begin
              nxt_state = S_DATA;
            end
          end
        end else if (r_hdr_cnt != 2'd0) begin
          if (w_idle_expired) begin
            nxt_state     = S_RESP;
            nxt_timeout   = 1'b1;
            nxt_err_seen  = 1'b1;
            nxt_idle      = '0;
            nxt_hdr_cnt   = '0;
            nxt_word      = '0;
            nxt_tx_tvalid = 1'b1;
            nxt_tx_tdata  = r_len;
            nxt_tx_tlast  = 1'b0;
          end else begin
            nxt_idle = r_idle + 32'd1;
          end
        end
      end

      S_DATA: begin
        if (w_rx_beat) begin
          nxt_idle = '0;
          nxt_idx  = r_idx + 32'd1;
          if (w_mismatch) begin
            nxt_err_seen = 1'b1;
            if (r_err_cnt != 32'hFFFF_FFFE) nxt_err_cnt = r_err_cnt + 32'd1;
`ifdef RX_MASS_FIRSTERR_EN
            if (r_err_cnt == '0) nxt_first_err = r_idx;
`endif
          end
          if (r_idx == r_len - 32'd1) begin
            nxt_state     = S_RESP;
            nxt_word      = '0;
            nxt_tx_tvalid = 1'b1;
            nxt_tx_tdata  = r_len;
            nxt_tx_tlast  = 1'b0;
          end
        end else if (w_idle_expired) begin
          nxt_state     = S_RESP;
          nxt_timeout   = 1'b1;
          nxt_err_seen  = 1'b1;
          nxt_idle      = '0;
          nxt_word      = '0;
          nxt_tx_tvalid = 1'b1;
          nxt_tx_tdata  = r_len;
          nxt_tx_tlast  = 1'b0;
        end else begin
          nxt_idle = r_idle + 32'd1;
        end
      end

      default: begin
        if (w_tx_beat) begin
          if (r_word == LAST_WORD) begin
            nxt_state     = S_HDR;
            nxt_word      = '0;
            nxt_len       = '0;
            nxt_hdr_cnt   = '0;
            nxt_err_cnt   = '0;
            nxt_timeout   = 1'b0;
            nxt_tx_tvalid = 1'b0;
            nxt_tx_tdata  = '0;
            nxt_tx_tlast  = 1'b0;
          end else begin
            nxt_word = r_word + 2'd1;
            unique case (nxt_word)
              2'd1:    nxt_tx_tdata = r_timeout ? 32'hFFFF_FFFF : r_err_cnt;
`ifdef RX_MASS_FIRSTERR_EN
              2'd2:    nxt_tx_tdata = r_first_err;
`endif
              default: nxt_tx_tdata = '0;
            endcase
            nxt_tx_tlast = (nxt_word == LAST_WORD);
          end
        end
      end
    endcase

    nxt_rx_tready = (nxt_state != S_RESP);
    nxt_tx_tkeep  = nxt_tx_tvalid ? 4'hF : 4'h0;
    nxt_busy      = (nxt_state == S_DATA) || ((nxt_state == S_HDR) && (nxt_hdr_cnt != 2'd0));
  end

  assign io_ftdi.rx_tready = r_rx_tready;
  assign io_ftdi.tx_tvalid = r_tx_tvalid;
  assign io_ftdi.tx_tdata  = r_tx_tdata;
  assign io_ftdi.tx_tkeep  = r_tx_tkeep;
  assign io_ftdi.tx_tlast  = r_tx_tlast;
  assign o_busy            = r_busy;
  assign o_err_seen        = r_err_seen;

endmodule
